// File: rtl/sha_block_sequencer.sv
// sha_block_sequencer: buffers 4x128-bit pre-padded words per block, drives SHA-256 core init/next, returns the final digest
// Ports: clk/clr (sync active-low reset); s_valid/s_ready/s_data/s_last word stream in;
//   core_init/core_next/core_block to the core, core_done/core_digest back from it;
//   m_valid/m_ready/m_digest digest stream out; busy, err (sticky) status.
module sha_block_sequencer #(
  parameter int WORD_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_last,
  output logic                core_init,
  output logic                core_next,
  output logic [4*WORD_W-1:0] core_block,
  input  logic                core_done,
  input  logic [255:0]        core_digest,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [255:0]        m_digest,
  output logic                busy,
  output logic                err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT, OUT} state_t;
  state_t              state_q, state_d;
  logic [1:0]          word_cnt_q, word_cnt_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [4*WORD_W-1:0] block_q, block_d;
  logic [255:0]        digest_q, digest_d;
  logic                m_valid_q, m_valid_d;
  logic                err_q, err_d;
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    first_d    = first_q;
    last_d     = last_q;
    tmo_cnt_d  = tmo_cnt_q;
    block_d    = block_q;
    digest_d   = digest_q;
    m_valid_d  = m_valid_q;
    err_d      = err_q;
    case (state_q)
      FILL: if (s_valid) begin
        // s_last before the 4th word is a framing error: drop the partial block
        if (s_last && word_cnt_q != 2'd3) begin
          err_d      = 1'b1;
          word_cnt_d = 2'd0;
          first_d    = 1'b1;
          block_d    = '0;
        end else begin
          block_d[(2'd3 - word_cnt_q)*WORD_W +: WORD_W] = s_data;
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            last_d  = s_last;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        first_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: if (core_done) begin
        tmo_cnt_d = '0;
        m_valid_d = last_q;
        digest_d  = last_q ? core_digest : digest_q;
        state_d   = last_q ? OUT : FILL;
      end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
        err_d      = 1'b1;
        first_d    = 1'b1;
        word_cnt_d = 2'd0;
        tmo_cnt_d  = '0;
        state_d    = FILL;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
      OUT: if (m_ready) begin
        m_valid_d = 1'b0;
        first_d   = 1'b1;
        state_d   = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= FILL;
      word_cnt_q <= 2'd0;
      first_q    <= 1'b1;
      last_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      block_q    <= '0;
      digest_q   <= '0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      first_q    <= first_d;
      last_q     <= last_d;
      tmo_cnt_q  <= tmo_cnt_d;
      block_q    <= block_d;
      digest_q   <= digest_d;
      m_valid_q  <= m_valid_d;
      err_q      <= err_d;
    end
  end
  assign s_ready    = state_q == FILL;
  assign core_init  = state_q == ISSUE && first_q;
  assign core_next  = state_q == ISSUE && !first_q;
  assign core_block = block_q;
  assign m_valid    = m_valid_q;
  assign m_digest   = digest_q;
  assign busy       = !(state_q == FILL && word_cnt_q == 2'd0);
  assign err        = err_q;
endmodule

// File: tb/tb_sha_block_sequencer.sv
// tb_sha_block_sequencer: directed bench with a real SHA-256 core model around sha_block_sequencer
module tb_sha_block_sequencer;
  logic         clk = 0, clr = 0, s_valid = 0, s_ready, s_last = 0;
  logic [127:0] s_data = '0;
  logic         core_init, core_next, core_done = 0;
  logic [511:0] core_block;
  logic [255:0] core_digest = '0, m_digest;
  logic         m_valid, m_ready = 0, busy, err;
  int           n_cmp = 0, n_bad = 0, n_init = 0, n_next = 0, cd_cnt = 0;
  bit           core_mute = 0, tmo_hit = 0;
  logic [511:0] init_blk = '0;
  logic [255:0] chain = '0;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [127:0] A0 = 128'h61626380_00000000_00000000_00000000;
  localparam logic [127:0] A3 = 128'h00000000_00000000_00000000_00000018;
  localparam logic [511:0] ABC_BLK = {A0, 128'h0, 128'h0, A3};
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [127:0] B0 = 128'h61626364_62636465_63646566_64656667;
  localparam logic [127:0] B1 = 128'h65666768_66676869_6768696a_68696a6b;
  localparam logic [127:0] B2 = 128'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f;
  localparam logic [127:0] B3 = 128'h6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [127:0] B7 = 128'h00000000_00000000_00000000_000001c0;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha_block_sequencer dut (
    .clk(clk), .clr(clr), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_init(core_init), .core_next(core_next), .core_block(core_block), .core_done(core_done),
    .core_digest(core_digest), .m_valid(m_valid), .m_ready(m_ready), .m_digest(m_digest),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_init || core_next) begin
      chain  <= sha_comp(core_init ? IV : chain, core_block);
      cd_cnt <= 64;
    end else if (cd_cnt > 1) begin
      cd_cnt <= cd_cnt - 1;
    end else if (cd_cnt == 1) begin
      cd_cnt <= 0;
      if (!core_mute) begin
        core_done   <= 1'b1;
        core_digest <= chain;
      end
    end
  end

  always @(negedge clk) begin
    if (core_init) begin
      n_init++;
      init_blk = core_block;
    end
    if (core_next) n_next++;
  end

  task automatic send(input logic [127:0] d, input logic l);
    int i;
    s_valid = 1; s_data = d; s_last = l; i = 0;
    while (!s_ready && i < 200) begin @(negedge clk); i++; end
    if (!s_ready) tmo_hit = 1;
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_abc;
    send(A0, 0); send('0, 0); send('0, 0); send(A3, 1);
  endtask

  task automatic wait_m;
    int i;
    i = 0;
    while (!m_valid && i < 300) begin @(negedge clk); i++; end
    if (!m_valid) tmo_hit = 1;
  endtask

  task automatic take;
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
  endtask

  task automatic do_reset;
    clr = 0;
    @(negedge clk);
    clr = 1;
  endtask

  task automatic test_reset;
    clr = 0;
    repeat (2) @(negedge clk);
    clr = 1;
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
    n_cmp++; if ({core_init, core_next} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got=%b want=00", {core_init, core_next}); end
    n_cmp++; if (core_block !== '0) begin n_bad++; $display("FAIL reset_core_block got=%h want=0", core_block); end
    n_cmp++; if (m_digest !== '0) begin n_bad++; $display("FAIL reset_m_digest got=%h want=0", m_digest); end
  endtask

  task automatic test_abc;
    int i0, x0;
    i0 = n_init; x0 = n_next;
    send(A0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abc_busy_partial got=%b want=1", busy); end
    send('0, 0); send('0, 0); send(A3, 1);
    n_cmp++; if (core_init !== 1'b1 || s_ready !== 1'b0) begin n_bad++; $display("FAIL abc_issue_latency got init=%b ready=%b want init=1 ready=0", core_init, s_ready); end
    wait_m;
    n_cmp++; if (n_init - i0 != 1 || n_next - x0 != 0) begin n_bad++; $display("FAIL abc_pulses got init=%0d next=%0d want 1/0", n_init - i0, n_next - x0); end
    n_cmp++; if (init_blk !== ABC_BLK) begin n_bad++; $display("FAIL abc_block got=%h want=%h", init_blk, ABC_BLK); end
    n_cmp++; if (m_digest !== ABC_D) begin n_bad++; $display("FAIL abc_digest got=%h want=%h", m_digest, ABC_D); end
    take;
    n_cmp++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL abc_handshake got valid=%b ready=%b busy=%b want 0/1/0", m_valid, s_ready, busy); end
    n_cmp++; if (tmo_hit !== 1'b0) begin n_bad++; $display("FAIL abc_stall got=1 want=0"); end
    tmo_hit = 0;
  endtask

  task automatic test_two_block;
    int i0, x0;
    i0 = n_init; x0 = n_next;
    send(B0, 0); send(B1, 0); send(B2, 0); send(B3, 0);
    send('0, 0); send('0, 0); send('0, 0); send(B7, 1);
    wait_m;
    n_cmp++; if (n_init - i0 != 1 || n_next - x0 != 1) begin n_bad++; $display("FAIL two_pulses got init=%0d next=%0d want 1/1", n_init - i0, n_next - x0); end
    n_cmp++; if (m_digest !== TWO_D) begin n_bad++; $display("FAIL two_digest got=%h want=%h", m_digest, TWO_D); end
    take;
    n_cmp++; if (tmo_hit !== 1'b0) begin n_bad++; $display("FAIL two_stall got=1 want=0"); end
    tmo_hit = 0;
  endtask

  task automatic test_back_pressure;
    send_abc;
    wait_m;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (m_valid !== 1'b1 || m_digest !== ABC_D || s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b digest=%h want 1/0/%h", i, m_valid, s_ready, m_digest, ABC_D); end
    end
    take;
    n_cmp++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", m_valid, s_ready); end
    n_cmp++; if (tmo_hit !== 1'b0) begin n_bad++; $display("FAIL bp_stall got=1 want=0"); end
    tmo_hit = 0;
  endtask

  task automatic test_bad_last;
    int i0;
    i0 = n_init;
    send(A0, 0); send(A0, 1);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err got=%b want=1", err); end
    n_cmp++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL bad_discard got ready=%b busy=%b want 1/0", s_ready, busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_init != i0 || core_next !== 1'b0) begin n_bad++; $display("FAIL bad_no_pulse got init=%0d want=%0d", n_init - i0, 0); end
    send_abc;
    wait_m;
    n_cmp++; if (m_digest !== ABC_D) begin n_bad++; $display("FAIL bad_recover_digest got=%h want=%h", m_digest, ABC_D); end
    take;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err_sticky got=%b want=1", err); end
    n_cmp++; if (tmo_hit !== 1'b0) begin n_bad++; $display("FAIL bad_stall got=1 want=0"); end
    tmo_hit = 0;
  endtask

  task automatic test_timeout;
    do_reset;
    core_mute = 1;
    send_abc;
    repeat (1024) @(negedge clk);
    n_cmp++; if (err !== 1'b0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL tmo_early got err=%b ready=%b want 0/0", err, s_ready); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1 || s_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_fire got err=%b ready=%b want 1/1", err, s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_no_digest got=%b want=0", m_valid); end
    core_mute = 0;
    n_cmp++; if (tmo_hit !== 1'b0) begin n_bad++; $display("FAIL tmo_stall got=1 want=0"); end
    tmo_hit = 0;
  endtask

  task automatic test_clr_mid_wait;
    bit bad;
    do_reset;
    send_abc;
    repeat (10) @(negedge clk);
    do_reset;
    n_cmp++; if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL clr_flags got ready=%b busy=%b valid=%b err=%b want 1/0/0/0", s_ready, busy, m_valid, err); end
    n_cmp++; if ({core_init, core_next} !== 2'b00 || core_block !== '0 || m_digest !== '0) begin n_bad++; $display("FAIL clr_data got pulses=%b block=%h digest=%h want zeros", {core_init, core_next}, core_block, m_digest); end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_digest !== '0) bad = 1;
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL clr_late_done got valid=%b ready=%b digest=%h want 0/1/0", m_valid, s_ready, m_digest); end
    n_cmp++; if (tmo_hit !== 1'b0) begin n_bad++; $display("FAIL clr_stall got=1 want=0"); end
    tmo_hit = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_abc;
    test_two_block;
    test_back_pressure;
    test_bad_last;
    test_timeout;
    test_clr_mid_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
